// File: rtl/run_length_detector.sv
// Serial run-length detector: tracks the current run of identical bits on w and flags runs of
// RUN_LEN zeros or ones, with overlap/non-overlap modes and a saturating detection counter.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned RunW   = $clog2(RUN_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             w,
  input  logic             overlap,
  input  logic             clear_count,
  output logic             z,
  output logic             z_zero,
  output logic             z_one,
  output logic [RunW-1:0]  run_cnt,
  output logic             run_val,
  output logic [CNT_W-1:0] det_count
);

  localparam logic [RunW-1:0] RunLenC = RunW'(RUN_LEN);
  localparam logic [RunW-1:0] OneC    = RunW'(1);

  typedef enum logic [1:0] {StIdle, StRun0, StRun1} state_e;

  state_e           state_q, state_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] det_count_q, det_count_d;
  logic             cur_val;
  logic             det_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      run_cnt_q   <= '0;
      det_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      det_count_q <= det_count_d;
    end
  end

  assign cur_val = (state_q == StRun1);

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          state_d   = w ? StRun1 : StRun0;
          run_cnt_d = OneC;
        end
        StRun0, StRun1: begin
          if (w != cur_val) begin
            state_d   = w ? StRun1 : StRun0;
            run_cnt_d = OneC;
          end else if (run_cnt_q == RunLenC) begin
            // Non-overlap mode restarts counting after a completed run.
            run_cnt_d = overlap ? RunLenC : OneC;
          end else begin
            run_cnt_d = run_cnt_q + OneC;
          end
        end
        default: begin
          state_d   = StIdle;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    det_inc     = enable && (run_cnt_d == RunLenC);
    det_count_d = det_count_q;
    if (clear_count) begin
      det_count_d = det_inc ? CNT_W'(1) : '0;
    end else if (det_inc && (det_count_q != '1)) begin
      det_count_d = det_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    z_one     = (state_q == StRun1) && (run_cnt_q == RunLenC);
    z_zero    = (state_q == StRun0) && (run_cnt_q == RunLenC);
    z         = z_one | z_zero;
    run_cnt   = run_cnt_q;
    run_val   = cur_val;
    det_count = det_count_q;
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Drives three configurations of run_length_detector (4/8, 4/2, 2/8) from shared inputs and
// compares every output after each edge against a per-configuration reference model.
module tb_run_length_detector;

  logic clock = 1'b0;
  logic reset, enable, w, overlap, clear_count;

  logic       z_a, zz_a, zo_a, rv_a;
  logic [2:0] rc_a;
  logic [7:0] dc_a;
  logic       z_b, zz_b, zo_b, rv_b;
  logic [2:0] rc_b;
  logic [1:0] dc_b;
  logic       z_c, zz_c, zo_c, rv_c;
  logic [1:0] rc_c;
  logic [7:0] dc_c;

  int tests = 0;
  int fails = 0;

  int lens [3] = '{4, 4, 2};
  int maxs [3] = '{255, 3, 255};
  bit m_valid [3];
  bit m_val [3];
  int m_cnt [3];
  int m_det [3];

  always #5 clock = ~clock;

  run_length_detector #(.RUN_LEN(4), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .overlap(overlap),
    .clear_count(clear_count), .z(z_a), .z_zero(zz_a), .z_one(zo_a), .run_cnt(rc_a),
    .run_val(rv_a), .det_count(dc_a)
  );

  run_length_detector #(.RUN_LEN(4), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .overlap(overlap),
    .clear_count(clear_count), .z(z_b), .z_zero(zz_b), .z_one(zo_b), .run_cnt(rc_b),
    .run_val(rv_b), .det_count(dc_b)
  );

  run_length_detector #(.RUN_LEN(2), .CNT_W(8)) u_c (
    .clock(clock), .reset(reset), .enable(enable), .w(w), .overlap(overlap),
    .clear_count(clear_count), .z(z_c), .z_zero(zz_c), .z_one(zo_c), .run_cnt(rc_c),
    .run_val(rv_c), .det_count(dc_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a run is (value, length); equal bits extend it, a different bit
  // starts a new run of 1, and a full run either stays full (overlap) or restarts at 1.
  task automatic model_edge();
    int nxt;
    bit inc;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_valid[i] = 0; m_val[i] = 0; m_cnt[i] = 0; m_det[i] = 0;
      end else begin
        nxt = m_cnt[i];
        if (enable) begin
          if (!m_valid[i] || (w != m_val[i])) nxt = 1;
          else if (m_cnt[i] == lens[i]) nxt = overlap ? lens[i] : 1;
          else nxt = m_cnt[i] + 1;
        end
        inc = enable && (nxt == lens[i]);
        if (clear_count) m_det[i] = inc ? 1 : 0;
        else if (inc && m_det[i] < maxs[i]) m_det[i] = m_det[i] + 1;
        if (enable) begin
          m_valid[i] = 1; m_val[i] = w; m_cnt[i] = nxt;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] oz, ozz, ozo, orv, orc, odc;
    bit full;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin oz = 32'(z_a); ozz = 32'(zz_a); ozo = 32'(zo_a); orv = 32'(rv_a);
                 orc = 32'(rc_a); odc = 32'(dc_a); end
        1: begin oz = 32'(z_b); ozz = 32'(zz_b); ozo = 32'(zo_b); orv = 32'(rv_b);
                 orc = 32'(rc_b); odc = 32'(dc_b); end
        default: begin oz = 32'(z_c); ozz = 32'(zz_c); ozo = 32'(zo_c); orv = 32'(rv_c);
                 orc = 32'(rc_c); odc = 32'(dc_c); end
      endcase
      full = m_valid[i] && (m_cnt[i] == lens[i]);
      chk($sformatf("%s[%0d].run_cnt", tag, i), orc, 32'(m_cnt[i]));
      chk($sformatf("%s[%0d].run_val", tag, i), orv, 32'(m_valid[i] && m_val[i]));
      chk($sformatf("%s[%0d].z_one", tag, i), ozo, 32'(full && m_val[i]));
      chk($sformatf("%s[%0d].z_zero", tag, i), ozz, 32'(full && !m_val[i]));
      chk($sformatf("%s[%0d].z", tag, i), oz, 32'(full));
      chk($sformatf("%s[%0d].det_count", tag, i), odc, 32'(m_det[i]));
    end
  endtask

  task automatic step(input string tag, input bit rst, input bit en, input bit wv,
                      input bit ov, input bit clr);
    @(negedge clock);
    reset = rst; enable = en; w = wv; overlap = ov; clear_count = clr;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1; enable = 0; w = 0; overlap = 1; clear_count = 0;

    step("reset", 1, 0, 0, 1, 0);
    chk("reset.z_a", 32'(z_a), 0);
    chk("reset.dc_a", 32'(dc_a), 0);

    // Overlapping ones, then a zero breaks the run.
    for (int i = 0; i < 5; i++) step("ov1", 0, 1, 1, 1, 0);
    chk("ov1.z_one_edge5", 32'(zo_a), 1);
    chk("ov1.dc_edge5", 32'(dc_a), 2);
    step("ov1_break", 0, 1, 0, 1, 0);
    chk("ov1.z_after_break", 32'(z_a), 0);
    chk("ov1.rc_after_break", 32'(rc_a), 1);

    // Non-overlapping zeros: detections on edges 4 and 8 only.
    step("rst2", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step("nov0", 0, 1, 0, 0, 0);
      if (i == 4 || i == 8) chk($sformatf("nov0.z_zero_e%0d", i), 32'(zz_a), 1);
      if (i == 5) chk("nov0.rc_e5", 32'(rc_a), 1);
    end
    chk("nov0.dc", 32'(dc_a), 2);

    // Enable low mid-run with w toggling.
    step("rst3", 1, 0, 0, 1, 0);
    step("en_run", 0, 1, 1, 1, 0);
    step("en_run", 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step("en_hold", 0, 0, i[0], 1, 0);
    chk("en_hold.rc", 32'(rc_a), 2);
    step("en_resume", 0, 1, 1, 1, 0);
    step("en_resume", 0, 1, 1, 1, 0);
    chk("en_resume.z", 32'(z_a), 1);

    // Narrow counter saturates, then clear coincides with a detection.
    step("rst4", 1, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step("sat", 0, 1, 1, 1, 0);
    chk("sat.dc_b", 32'(dc_b), 3);
    step("sat_clr", 0, 1, 1, 1, 1);
    chk("sat_clr.dc_b", 32'(dc_b), 1);

    // Reset on the edge that would complete a run.
    step("rst5", 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("rst_mid", 0, 1, 0, 1, 0);
    step("rst_mid_hit", 1, 1, 0, 1, 0);
    chk("rst_mid.z", 32'(z_a), 0);
    chk("rst_mid.dc", 32'(dc_a), 0);
    step("rst_mid_next", 0, 1, 0, 1, 0);
    chk("rst_mid.rc", 32'(rc_a), 1);

    // RUN_LEN=2: overlap switched off while full.
    step("rst6", 1, 0, 0, 1, 0);
    step("ovsw", 0, 1, 1, 1, 0);
    step("ovsw", 0, 1, 1, 1, 0);
    chk("ovsw.z_c_full", 32'(z_c), 1);
    step("ovsw_off", 0, 1, 1, 0, 0);
    chk("ovsw.rc_c", 32'(rc_c), 1);
    chk("ovsw.z_c_off", 32'(z_c), 0);
    step("ovsw_next", 0, 1, 1, 0, 0);
    chk("ovsw.z_c_again", 32'(z_c), 1);
    chk("ovsw.dc_c", 32'(dc_c), 2);

    // Random traffic, mostly enabled, with runs biased long.
    step("rst7", 1, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 75),
           ($urandom_range(0, 99) < 30) ? ~w : w, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
